// File: rtl/als_pkg.sv
// Shared definitions for the ambient-light-sensor scheduler: FSM encoding and
// the position of the light value inside the raw ALS frame.
package als_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    ACCUM     = 3'd4,
    SEND      = 3'd5
  } als_state_t;

  localparam int ALS_FIELD_MSB = 11;
  localparam int ALS_FIELD_LSB = 4;

endpackage

// File: rtl/period_ticker.sv
// Free-running 0..SAMPLE_PERIOD-1 counter; tick is high on the cycle it wraps.
module period_ticker #(
  parameter int SAMPLE_PERIOD = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = $clog2(SAMPLE_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_PERIOD - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/als_scheduler.sv
// Periodically triggers the ALS reader, averages 2^AVG_LOG2 light bytes and
// hands each averaged byte to the UART transmitter.
//
// UART handshake: tx_start is a one-cycle request that is only raised while
// tx_busy is low; tx_data is valid in that cycle and held until the next send.
module als_scheduler
  import als_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 50_000_000,
  parameter int AVG_LOG2      = 2,
  parameter int TIMEOUT       = 100_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        als_initiate,
  input  logic        als_ready,
  input  logic [15:0] als_data,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic [7:0]  result,
  output logic        result_valid,
  output logic        overrun,
  output logic        timeout_err,
  output als_state_t  state
);

  localparam int ACC_W = 8 + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  als_state_t       state_next;
  logic             tick;
  logic [TMO_W-1:0] tmo_cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic [CNT_W-1:0] count;
  logic [7:0]       sample;
  logic [7:0]       tx_data_q;
  logic             tmo_hit;
  logic             last;
  logic             unused_bits;

  period_ticker #(.SAMPLE_PERIOD(SAMPLE_PERIOD)) u_ticker (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign unused_bits = ^{als_data[15:ALS_FIELD_MSB+1], als_data[ALS_FIELD_LSB-1:0]};
  assign tmo_hit     = (tmo_cnt == TMO_LAST);
  assign last        = (count == CNT_LAST);
  assign sum         = acc + ACC_W'(sample);

  // The send waits out the result_valid cycle so tx_start always trails it.
  assign als_initiate = (state == START);
  assign tx_start     = (state == SEND) && !tx_busy && !result_valid;
  assign tx_data      = tx_start ? result : tx_data_q;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (tick && enable) state_next = START;
      START:     state_next = WAIT_BUSY;
      WAIT_BUSY: if (!als_ready) state_next = WAIT_DONE;
                 else if (tmo_hit) state_next = IDLE;
      WAIT_DONE: if (als_ready) state_next = ACCUM;
                 else if (tmo_hit) state_next = IDLE;
      ACCUM:     state_next = last ? SEND : IDLE;
      SEND:      if (tx_start) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      tmo_cnt      <= '0;
      acc          <= '0;
      count        <= '0;
      sample       <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      tx_data_q    <= '0;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_next;
      result_valid <= 1'b0;
      if (tick && state != IDLE) overrun <= 1'b1;
      case (state)
        START: tmo_cnt <= '0;
        WAIT_BUSY, WAIT_DONE: begin
          tmo_cnt <= (state_next != state) ? '0 : tmo_cnt + TMO_W'(1);
          if (state_next == IDLE) begin
            // Timed out: a partial average is worthless, start over.
            timeout_err <= 1'b1;
            acc         <= '0;
            count       <= '0;
          end
          if (state == WAIT_DONE && als_ready)
            sample <= als_data[ALS_FIELD_MSB:ALS_FIELD_LSB];
        end
        ACCUM: begin
          if (last) begin
            result       <= 8'(sum >> AVG_LOG2);
            result_valid <= 1'b1;
            acc          <= '0;
            count        <= '0;
          end else begin
            acc   <= sum;
            count <= count + CNT_W'(1);
          end
        end
        SEND: if (tx_start) tx_data_q <= result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_als_scheduler.sv
// Directed bench for als_scheduler: an averaging instance (AVG_LOG2=2) and a
// pass-through instance (AVG_LOG2=0), each driven by a small ALS reader model.
module tb_als_scheduler;
  import als_pkg::*;

  localparam int P   = 20;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        als_initiate, als_ready, tx_start, tx_busy, result_valid, overrun, timeout_err;
  logic [15:0] als_data;
  logic [7:0]  tx_data, result;
  als_state_t  state;

  logic        enable0 = 1'b1;
  logic        als_initiate0, als_ready0, tx_start0, result_valid0, overrun0, timeout_err0;
  logic        tx_busy0 = 1'b0;
  logic [15:0] als_data0;
  logic [7:0]  tx_data0, result0;
  als_state_t  state0;

  int n_checks = 0, n_pass = 0, cyc = 0;
  int n_init = 0, n_rv = 0, n_tx = 0, busy_viol = 0, rv_tx_overlap = 0, rise_cyc = 0;
  int n_init0 = 0, init0_c0 = 0, init0_c1 = 0, n_rv0 = 0, n_tx0 = 0;
  logic [7:0] first_res0 = '0, first_tx0 = '0;
  logic [7:0] exp_q[$];
  logic [7:0] als_bytes[$];
  bit dead = 1'b0;

  als_scheduler #(.SAMPLE_PERIOD(P), .AVG_LOG2(2), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .enable(enable), .als_initiate(als_initiate),
    .als_ready(als_ready), .als_data(als_data), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .result(result), .result_valid(result_valid), .overrun(overrun),
    .timeout_err(timeout_err), .state(state)
  );

  als_scheduler #(.SAMPLE_PERIOD(P), .AVG_LOG2(0), .TIMEOUT(TMO)) dut0 (
    .clk(clk), .reset(reset), .enable(enable0), .als_initiate(als_initiate0),
    .als_ready(als_ready0), .als_data(als_data0), .tx_data(tx_data0), .tx_start(tx_start0),
    .tx_busy(tx_busy0), .result(result0), .result_valid(result_valid0), .overrun(overrun0),
    .timeout_err(timeout_err0), .state(state0)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_init(input int target, input int budget, input string tag);
    for (int k = 0; k < budget && n_init < target; k++) step();
    check(tag, 32'(n_init), 32'(target));
  endtask

  task automatic wait_rv(input int budget, input string tag);
    for (int k = 0; k < budget && !result_valid; k++) step();
    check(tag, 32'(result_valid), 32'd1);
  endtask

  task automatic wait_state(input als_state_t s, input int budget, input string tag);
    for (int k = 0; k < budget && state != s; k++) step();
    check(tag, 32'(state), 32'(s));
  endtask

  // ALS reader models: ready drops for 3 cycles after initiate, then data appears
  initial begin
    logic [7:0] b;
    als_ready = 1'b1;
    als_data  = '0;
    forever begin
      @(negedge clk);
      if (als_initiate && !dead) begin
        als_ready = 1'b0;
        repeat (3) @(negedge clk);
        b = (als_bytes.size() > 0) ? als_bytes.pop_front() : 8'h00;
        als_data  = {4'h0, b, 4'h0};
        als_ready = 1'b1;
        rise_cyc  = cyc;
      end
    end
  end

  initial begin
    als_ready0 = 1'b1;
    als_data0  = 16'h0AB0;
    forever begin
      @(negedge clk);
      if (als_initiate0) begin
        als_ready0 = 1'b0;
        repeat (3) @(negedge clk);
        als_ready0 = 1'b1;
      end
    end
  end

  // monitor + scoreboard
  always @(negedge clk) begin
    if (als_initiate) n_init++;
    if (result_valid) n_rv++;
    if (tx_start) begin
      n_tx++;
      if (tx_busy) busy_viol++;
      if (result_valid) rv_tx_overlap++;
      if (exp_q.size() > 0) check("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
      else check("tx_unexpected", 32'(exp_q.size()), 32'd1);
    end
    if (als_initiate0) begin
      n_init0++;
      if (n_init0 == 1) init0_c0 = cyc;
      else if (n_init0 == 2) init0_c1 = cyc;
    end
    if (result_valid0) begin
      n_rv0++;
      if (n_rv0 == 1) first_res0 = result0;
    end
    if (tx_start0) begin
      n_tx0++;
      if (n_tx0 == 1) first_tx0 = tx_data0;
    end
  end

  initial begin
    int t_en;
    tx_busy = 1'b0;
    repeat (3) step();
    check("rst_outputs", 32'({als_initiate, tx_start, result_valid, overrun, timeout_err, tx_data, result}), 32'd0);
    check("rst_state", 32'(state), 32'(IDLE));
    check("rst_state0", 32'(state0), 32'(IDLE));
    reset = 1'b0;

    // enable low for 100 cycles, then four conversions averaged to 47>>2
    als_bytes.push_back(8'd10); als_bytes.push_back(8'd11);
    als_bytes.push_back(8'd12); als_bytes.push_back(8'd14);
    exp_q.push_back(8'd11);
    repeat (100) step();
    check("no_init_while_disabled", 32'(n_init), 32'd0);
    enable = 1'b1;
    t_en = cyc;
    wait_init(1, 25, "first_init");
    check("init_within_period", 32'((cyc - t_en) >= 1 && (cyc - t_en) <= P + 1), 32'd1);
    wait_init(3, 60, "init3");
    repeat (15) step();
    check("no_rv_before_4th", 32'(n_rv), 32'd0);
    check("no_tx_before_4th", 32'(n_tx), 32'd0);
    check("no_overrun_normal", 32'(overrun), 32'd0);

    // transmitter busy when SEND is entered
    tx_busy = 1'b1;
    wait_rv(30, "rv_avg4");
    check("result_avg4", 32'(result), 32'd11);
    check("rv_latency", 32'(cyc - rise_cyc), 32'd2);
    check("state_send", 32'(state), 32'(SEND));
    repeat (50) step();
    check("no_tx_while_busy", 32'(n_tx), 32'd0);
    check("overrun_in_send", 32'(overrun), 32'd1);
    check("still_send", 32'(state), 32'(SEND));
    tx_busy = 1'b0;
    #1;
    check("tx_start_on_release", 32'(tx_start), 32'd1);
    check("tx_data_on_release", 32'(tx_data), 32'd11);
    step();
    check("tx_start_one_cycle", 32'(tx_start), 32'd0);
    check("idle_after_send", 32'(state), 32'(IDLE));
    check("tx_data_held", 32'(tx_data), 32'd11);

    // enable dropped during the 4th conversion's WAIT_DONE: 810>>2 = 202
    als_bytes.push_back(8'd100); als_bytes.push_back(8'd200);
    als_bytes.push_back(8'd255); als_bytes.push_back(8'd255);
    exp_q.push_back(8'd202);
    wait_init(8, 100, "init8");
    wait_state(WAIT_DONE, 10, "wait_done8");
    enable = 1'b0;
    wait_rv(15, "rv_enable_drop");
    check("result_enable_drop", 32'(result), 32'd202);
    repeat (60) step();
    check("tx_after_drop", 32'(n_tx), 32'd2);
    check("no_init_after_drop", 32'(n_init), 32'd8);

    // one good conversion, then a dead ALS: partial average must be discarded
    als_bytes.push_back(8'd40);
    enable = 1'b1;
    wait_init(9, 25, "init9");
    repeat (15) step();
    dead = 1'b1;
    for (int k = 0; k < 25 && !als_initiate; k++) step();
    check("dead_init", 32'(als_initiate), 32'd1);
    repeat (TMO) step();
    check("wait_busy_before_tmo", 32'(state), 32'(WAIT_BUSY));
    check("tmo_not_yet", 32'(timeout_err), 32'd0);
    step();
    check("timeout_err", 32'(timeout_err), 32'd1);
    check("idle_after_tmo", 32'(state), 32'(IDLE));
    dead = 1'b0;
    als_bytes.push_back(8'd20); als_bytes.push_back(8'd20);
    als_bytes.push_back(8'd20); als_bytes.push_back(8'd24);
    exp_q.push_back(8'd21);
    wait_init(11, 25, "init_after_tmo");
    check("no_rv_from_tmo", 32'(n_rv), 32'd2);
    wait_init(14, 100, "init14");
    wait_rv(15, "rv_after_tmo");
    check("result_after_discard", 32'(result), 32'd21);

    // reset during WAIT_DONE of a second conversion; accumulation restarts
    als_bytes.push_back(8'd50); als_bytes.push_back(8'd60);
    als_bytes.push_back(8'd1);  als_bytes.push_back(8'd2);
    als_bytes.push_back(8'd3);  als_bytes.push_back(8'd6);
    exp_q.push_back(8'd3);
    wait_init(16, 60, "init16");
    wait_state(WAIT_DONE, 10, "wait_done16");
    reset = 1'b1;
    step();
    check("mid_rst_outputs", 32'({als_initiate, tx_start, result_valid, overrun, timeout_err, tx_data, result}), 32'd0);
    check("mid_rst_state", 32'(state), 32'(IDLE));
    reset = 1'b0;
    wait_init(20, 120, "init20");
    wait_rv(15, "rv_after_reset");
    check("result_after_reset", 32'(result), 32'd3);
    repeat (10) step();

    // final report
    check("tx_count", 32'(n_tx), 32'd4);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("tx_while_busy", 32'(busy_viol), 32'd0);
    check("tx_with_rv", 32'(rv_tx_overlap), 32'd0);
    check("p0_init_period", 32'(init0_c1 - init0_c0), 32'(P));
    check("p0_result", 32'(first_res0), 32'h0AB);
    check("p0_tx_data", 32'(first_tx0), 32'h0AB);
    check("p0_tx_seen", 32'(n_tx0 > 0), 32'd1);
    check("p0_no_overrun", 32'(overrun0), 32'd0);
    check("p0_no_timeout", 32'(timeout_err0), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
